dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Parametrised next-generation data-memory stage: direct-mapped, write-back, write-allocate data cache with its own miss FSM.
- Talks to a variable-latency block memory through a req/ack handshake and stalls the pipeline on misses.
- Sits in the memory stage between the ALU result and the writeback result mux.
- Replaces the fixed single-cycle fetch/write-back path with configurable line size, set count and explicit dirty tracking.

Parameters:
DATA_WIDTH, 32, word width in bits; byte/half sub-word access assumes 32.
ADDR_WIDTH, 32, byte address width.
LINE_WORDS, 4, words per line; power of 2, at least 1.
SETS, 64, number of lines; power of 2, at least 2.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
MemRead  in  1  load request this cycle
MemWrite  in  1  store request this cycle; MemRead and MemWrite are never both high
addr  in  ADDR_WIDTH  byte address (ALU result)
WriteData  in  DATA_WIDTH  store data, low bits used for SB/SH
funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ReadData  out  DATA_WIDTH  extended load data
stall  out  1  high while the request cannot complete this cycle
mem_req  out  1  block-memory request
mem_we  out  1  1 = write line, 0 = read line
mem_addr  out  ADDR_WIDTH  line-aligned byte address
mem_wdata  out  LINE_WORDS*DATA_WIDTH  victim line, word 0 in LSBs
mem_rdata  in  LINE_WORDS*DATA_WIDTH  refill line, valid when mem_ack is high
mem_ack  in  1  one-cycle completion pulse, sampled only while mem_req is high

Behaviour:
- Address split, LSB up: byte offset 2 bits, word select log2(LINE_WORDS), index log2(SETS), tag = remainder.
- Per-line state: valid bit, dirty bit, tag, data.
- Alignment: halfword uses addr[1]; word ignores addr[1:0]; addr[0] is ignored for halfword.
- Reset (async): every valid and dirty bit cleared, FSM to IDLE; mem_req=0, mem_we=0, stall=0, ReadData=0. Data arrays are not cleared.
- Reset mid-transaction abandons it immediately. Memory side must tolerate mem_req dropping without ack.
- FSM states: IDLE, WB, REFILL, RESP.
- IDLE, no request: stall=0, ReadData=0.
- IDLE, hit (valid and tag match):
  - Load: ReadData is combinational in the same cycle, stall=0.
  - Store: byte/half/word merged into the line at the clock edge, dirty set, stall=0.
  - Zero added latency in both cases.
- IDLE, miss: stall=1 combinationally in the same cycle.
  - Victim valid and dirty -> WB.
  - Otherwise -> REFILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line.
  - On mem_ack -> REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, 0}.
  - On mem_ack: install mem_rdata and tag, set valid, clear dirty -> RESP.
- RESP:
  - Access is now a hit. stall=0, load data presented, store merged and dirty set.
  - Next state IDLE.
- mem_addr, mem_we and mem_wdata are stable while mem_req is high. mem_ack may arrive in the first cycle of mem_req (minimum latency).
- mem_req is deasserted for at least one cycle between WB and REFILL.
- Miss latency: stall cycles = 1 + refill wait (+ 1 + write-back wait if dirty). The request completes in RESP.
- Pipeline contract: addr, WriteData, funct3, MemRead and MemWrite are held stable while stall=1. The block may ignore changes to them.
- Load extension:
  - B/H are sign-extended from bit 7/15.
  - BU/HU are zero-extended.
  - Undefined funct3 codes behave as W.
- Stores: SB writes 1 byte, SH 2 bytes, SW 4 bytes at the selected word. Other bytes of the line are unchanged.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Cold read: reset, LW addr 0x100, refill ack after 3 cycles with word0=0xDEADBEEF -> stall high 5 cycles, ReadData=0xDEADBEEF in RESP, no WB request issued.
- Hit after refill: LW addr 0x104 next cycle -> stall=0, data equals refill word1, mem_req stays 0.
- Sub-word store and signed load:
  - SB 0x80 to addr 0x101 on a resident line, then LB 0x101 -> 0xFFFFFF80.
  - LBU 0x101 -> 0x00000080.
  - LHU 0x100 -> 0x000080EF.
- Dirty eviction: store to 0x100, then LW to an address with the same index and a different tag -> WB with mem_addr=0x100 and the modified line, then REFILL of the new line; stall covers both phases.
- Zero-latency and reset abort:
  - mem_ack in the same cycle as mem_req -> RESP on the next cycle.
  - rst asserted mid-REFILL -> mem_req and stall drop asynchronously, the previously resident line now misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped, write-back, write-allocate data cache for the
//            memory stage. A small miss FSM moves lines to and from a
//            variable-latency block memory over a req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             MemRead,
  input  logic                             MemWrite,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            WriteData,
  input  logic [2:0]                       funct3,
  output logic [DATA_WIDTH-1:0]            ReadData,
  output logic                             stall,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata,
  input  logic                             mem_ack
);

  localparam int c_LINE_BITS = LINE_WORDS * DATA_WIDTH;
  localparam int c_WS_BITS   = $clog2(LINE_WORDS);
  localparam int c_WSEL_W    = (c_WS_BITS > 0) ? c_WS_BITS : 1;
  localparam int c_IDX_W     = $clog2(SETS);
  localparam int c_IDX_LSB   = 2 + c_WS_BITS;
  localparam int c_TAG_LSB   = c_IDX_LSB + c_IDX_W;
  localparam int c_TAG_W     = ADDR_WIDTH - c_TAG_LSB;
  localparam int c_BYTES     = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     gap_q, gap_d;        // forces one idle cycle on the bus after a write-back
  logic [SETS-1:0]          valid_q;
  logic [SETS-1:0]          dirty_q;
  logic [c_TAG_W-1:0]       tag_q  [SETS];
  logic [c_LINE_BITS-1:0]   data_q [SETS];

  logic [c_TAG_W-1:0]       w_tag;
  logic [c_IDX_W-1:0]       w_idx;
  logic [c_WSEL_W-1:0]      w_wsel;
  logic                     w_hit;
  logic [c_LINE_BITS-1:0]   w_line;
  logic [DATA_WIDTH-1:0]    w_word;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic                     w_load;
  logic                     w_store;
  logic                     w_fill;
  logic [c_BYTES-1:0]       w_be;
  logic [DATA_WIDTH-1:0]    w_wrep;

  assign w_tag = addr[ADDR_WIDTH-1:c_TAG_LSB];
  assign w_idx = addr[c_TAG_LSB-1:c_IDX_LSB];

  generate
    if (c_WS_BITS > 0) begin : g_wsel
      assign w_wsel = addr[c_IDX_LSB-1:2];
    end else begin : g_wsel_single
      assign w_wsel = 1'b0;
    end
  endgenerate

  assign w_hit  = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_line = data_q[w_idx];
  assign w_word = w_line[int'(w_wsel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_byte = w_word[int'(addr[1:0])*8 +: 8];
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];

  // Miss FSM next state and all handshake/pipeline outputs; reset forces everything quiet
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_fill    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (MemRead || MemWrite) begin
            if (w_hit) begin
              w_load  = MemRead;
              w_store = MemWrite;
            end else begin
              stall   = 1'b1;
              state_d = (valid_q[w_idx] && dirty_q[w_idx]) ? S_WB : S_REFILL;
            end
          end
        end
        S_WB: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {tag_q[w_idx], w_idx, {c_IDX_LSB{1'b0}}};
          mem_wdata = w_line;
          if (mem_ack) begin
            gap_d   = 1'b1;
            state_d = S_REFILL;
          end
        end
        S_REFILL: begin
          stall    = 1'b1;
          mem_addr = {w_tag, w_idx, {c_IDX_LSB{1'b0}}};
          if (gap_q) begin
            gap_d = 1'b0;
          end else begin
            mem_req = 1'b1;
            if (mem_ack) begin
              w_fill  = 1'b1;
              state_d = S_RESP;
            end
          end
        end
        S_RESP: begin
          w_load  = MemRead;
          w_store = MemWrite;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Load data extension; zero whenever no load completes this cycle
  always_comb begin
    ReadData = '0;
    if (w_load) begin
      case (funct3)
        3'b000:  ReadData = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
        3'b001:  ReadData = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        3'b100:  ReadData = {{(DATA_WIDTH-8){1'b0}}, w_byte};
        3'b101:  ReadData = {{(DATA_WIDTH-16){1'b0}}, w_half};
        default: ReadData = w_word;
      endcase
    end
  end

  // Store byte enables and lane-replicated store data
  always_comb begin
    w_be   = '1;
    w_wrep = WriteData;
    case (funct3[1:0])
      2'b00: begin
        w_be             = '0;
        w_be[addr[1:0]]  = 1'b1;
        w_wrep           = {c_BYTES{WriteData[7:0]}};
      end
      2'b01: begin
        w_be                  = '0;
        w_be[{addr[1], 1'b0}] = 1'b1;
        w_be[{addr[1], 1'b1}] = 1'b1;
        w_wrep                = {(c_BYTES/2){WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Control state with asynchronous reset: FSM, gap flag, valid and dirty bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (w_fill) begin
        valid_q[w_idx] <= 1'b1;
        dirty_q[w_idx] <= 1'b0;
      end
      if (w_store) begin
        dirty_q[w_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: refill installs the whole line, stores merge selected bytes
  always_ff @(posedge clk) begin
    if (w_fill) begin
      data_q[w_idx] <= mem_rdata;
      tag_q[w_idx]  <= w_tag;
    end else if (w_store) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (w_be[b]) begin
          data_q[w_idx][int'(w_wsel)*DATA_WIDTH + b*8 +: 8] <= w_wrep[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
